// File: rtl/clken_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clken_gen : NCH fractional NUM/DEN clock-enable strobes plus delayed copies
// Rev 1.0
// ---------------------------------------------------------------------------
module clken_gen #(
  parameter int                   NCH      = 2,
  parameter int                   ACC_W    = 8,
  parameter int                   DEN      = 25,
  parameter logic [NCH*ACC_W-1:0] NUM_INIT = {8'd6, 8'd8},
  parameter int                   DLY      = 2,
  localparam int                  SEL_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sync,
  input  logic             num_wr,
  input  logic [SEL_W-1:0] num_sel,
  input  logic [ACC_W-1:0] num_data,
  output logic             num_busy,
  output logic             frame_start,
  output logic [NCH-1:0]   cen,
  output logic [NCH-1:0]   cen_dly
);

  localparam logic [ACC_W:0]   DEN_W     = (ACC_W+1)'(DEN);
  localparam logic [ACC_W-1:0] DEN_N     = ACC_W'(DEN);
  localparam logic [ACC_W-1:0] FCNT_LAST = ACC_W'(DEN - 1);
  localparam logic [SEL_W:0]   NCH_W     = (SEL_W+1)'(NCH);

  logic [NCH-1:0][ACC_W-1:0] acc_q, acc_d;
  logic [NCH-1:0][ACC_W-1:0] num_q, num_d;
  logic [NCH-1:0]            cen_q, cen_d;
  logic [ACC_W-1:0]          fcnt_q, fcnt_d;
  logic                      fs_q, fs_d;
  logic                      busy_q, busy_d;
  logic [ACC_W-1:0]          pval_q, pval_d;
  logic [SEL_W-1:0]          psel_q, psel_d;
  logic [DLY-1:0][NCH-1:0]   dly_q, dly_d;

  logic w_wrap;
  logic w_apply;
  logic w_wr_ok;

  assign w_wrap  = (fcnt_q == FCNT_LAST);
  assign w_apply = sync | w_wrap;
  assign w_wr_ok = num_wr & ({1'b0, num_sel} < NCH_W);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [ACC_W-1:0] n_eff;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] diff;
    logic             hit;

    // Numerators above DEN saturate to a continuous enable.
    assign n_eff = ({1'b0, num_q[i]} > DEN_W) ? DEN_N : num_q[i];
    assign sum   = {1'b0, acc_q[i]} + {1'b0, n_eff};
    assign hit   = (sum >= DEN_W);
    assign diff  = sum[ACC_W-1:0] - DEN_N;

    assign acc_d[i] = sync ? '0 : (hit ? diff : sum[ACC_W-1:0]);
    assign cen_d[i] = ~sync & hit;
    assign num_d[i] = (w_apply && busy_q && (psel_q == SEL_W'(i))) ? pval_q : num_q[i];
  end

  if (DLY == 1) begin : g_dly1
    assign dly_d = cen_q;
  end else begin : g_dlyn
    assign dly_d = {dly_q[DLY-2:0], cen_q};
  end

  // A write landing on the apply edge survives as the next pending value.
  always_comb begin
    fcnt_d = w_wrap ? '0 : fcnt_q + ACC_W'(1);
    fs_d   = w_wrap;
    busy_d = busy_q;
    pval_d = pval_q;
    psel_d = psel_q;
    if (sync) begin
      fcnt_d = '0;
      fs_d   = 1'b1;
    end
    if (w_apply) begin
      busy_d = 1'b0;
    end
    if (w_wr_ok) begin
      busy_d = 1'b1;
      pval_d = num_data;
      psel_d = num_sel;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q  <= '0;
      num_q  <= NUM_INIT;
      cen_q  <= '0;
      fcnt_q <= '0;
      fs_q   <= 1'b0;
      busy_q <= 1'b0;
      pval_q <= '0;
      psel_q <= '0;
      dly_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      num_q  <= num_d;
      cen_q  <= cen_d;
      fcnt_q <= fcnt_d;
      fs_q   <= fs_d;
      busy_q <= busy_d;
      pval_q <= pval_d;
      psel_q <= psel_d;
      dly_q  <= dly_d;
    end
  end

  assign cen         = cen_q;
  assign cen_dly     = dly_q[DLY-1];
  assign frame_start = fs_q;
  assign num_busy    = busy_q;

endmodule
`default_nettype wire
